// File: rtl/ex_stage_if.sv
// ----------------------------------------------------------------------------
// ex_stage_if
// Purpose : Groups the execute-stage buses of the 5-stage MIPS core into one
//           interface. The stage itself connects through the slave modport.
//           The surrounding pipeline (decode, memory stage, data SRAM,
//           stall controller) connects through the master modport.
// Signals :
//   stall           per-stage stall vector, 1 = stop (bit 2 = EX, bit 3 = MEM)
//   id_to_ex_bus    decode -> execute instruction bundle
//   ex_to_mem_bus   execute -> memory bundle
//   ex_to_id_bus    {rf_we, rf_waddr, result} forwarding source for decode
//   stallreq_load   EX holds a load with a nonzero destination
//   data_sram_en    data SRAM access enable
//   data_sram_wen   data SRAM byte write enables
//   data_sram_addr  data SRAM byte address
//   data_sram_wdata data SRAM store data
// ----------------------------------------------------------------------------
interface ex_stage_if #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_ID_WD  = 38,
    parameter int STALL_WD     = 6
);
    logic [STALL_WD-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic                    stallreq_load;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, stallreq_load,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, stallreq_load,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Purpose : Execute stage of the 5-stage MIPS core. Registers the decode
//           bundle, computes the ALU result, issues the data SRAM request for
//           loads/stores, forwards {rf_we, rf_waddr, result} back to decode
//           and flags a load-use hazard candidate.
// Ports   :
//   clk  in  core clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  ex_stage_if.slave
//          in : stall, id_to_ex_bus
//          out: ex_to_mem_bus, ex_to_id_bus, stallreq_load,
//               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
// All outputs are combinational from the pipeline register, so an
// instruction captured on an edge is visible on every output in that cycle.
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_ID_WD  = 38,
    parameter int STALL_WD     = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus
);

    // ---------------- stage boundary: decode -> execute register ----------------
    logic [ID_TO_EX_WD-1:0] id_ex_p0;

    // stall[2] alone drains EX with a bubble; stall[2] with stall[3] freezes it
    // because the memory stage cannot accept the current instruction yet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_p0 <= '0;
        end else if (bus.stall[2]) begin
            if (!bus.stall[3]) begin
                id_ex_p0 <= '0;
            end
        end else begin
            id_ex_p0 <= bus.id_to_ex_bus;
        end
    end

    logic [31:0] pc_p0;
    logic [31:0] inst_p0;
    logic [11:0] alu_op_p0;
    logic [2:0]  src1_sel_p0;
    logic [3:0]  src2_sel_p0;
    logic        ram_en_p0;
    logic [3:0]  ram_wen_p0;
    logic        rf_we_p0;
    logic [4:0]  rf_waddr_p0;
    logic        sel_rf_res_p0;
    logic [31:0] rdata1_p0;
    logic [31:0] rdata2_p0;

    assign pc_p0         = id_ex_p0[158:127];
    assign inst_p0       = id_ex_p0[126:95];
    assign alu_op_p0     = id_ex_p0[94:83];
    assign src1_sel_p0   = id_ex_p0[82:80];
    assign src2_sel_p0   = id_ex_p0[79:76];
    assign ram_en_p0     = id_ex_p0[75];
    assign ram_wen_p0    = id_ex_p0[74:71];
    assign rf_we_p0      = id_ex_p0[70];
    assign rf_waddr_p0   = id_ex_p0[69:65];
    assign sel_rf_res_p0 = id_ex_p0[64];
    assign rdata1_p0     = id_ex_p0[63:32];
    assign rdata2_p0     = id_ex_p0[31:0];

    // Opcode/register fields of inst are decoded upstream; only the
    // immediate and shift amount are consumed here.
    logic unused_fields;
    assign unused_fields = ^{inst_p0[31:16], bus.stall[STALL_WD-1:4], bus.stall[1:0]};

    // Operand muxes are AND-OR over one-hot selects, so an empty select
    // yields 0 and an illegal multi-hot select ORs the candidates.
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] sa_zext;

    assign imm_sext = {{16{inst_p0[15]}}, inst_p0[15:0]};
    assign imm_zext = {16'b0, inst_p0[15:0]};
    assign sa_zext  = {27'b0, inst_p0[10:6]};

    assign src1 = ({32{src1_sel_p0[0]}} & rdata1_p0)
                | ({32{src1_sel_p0[1]}} & pc_p0)
                | ({32{src1_sel_p0[2]}} & sa_zext);

    assign src2 = ({32{src2_sel_p0[0]}} & rdata2_p0)
                | ({32{src2_sel_p0[1]}} & imm_sext)
                | ({32{src2_sel_p0[2]}} & 32'd8)
                | ({32{src2_sel_p0[3]}} & imm_zext);

    logic signed [31:0] src1_s;
    logic signed [31:0] src2_s;
    assign src1_s = $signed(src1);
    assign src2_s = $signed(src2);

    logic [4:0]  shamt;
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;

    assign shamt    = src1[4:0];
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, (src1_s < src2_s)};
    assign sltu_res = {31'b0, (src1 < src2)};
    assign sll_res  = src2 << shamt;
    assign srl_res  = src2 >> shamt;
    assign sra_res  = $unsigned(src2_s >>> shamt);
    assign lui_res  = {src2[15:0], 16'b0};

    // alu_op bit order, MSB first: add sub slt sltu and nor or xor sll srl sra lui
    logic [31:0] result;
    assign result = ({32{alu_op_p0[11]}} & add_res)
                  | ({32{alu_op_p0[10]}} & sub_res)
                  | ({32{alu_op_p0[9]}}  & slt_res)
                  | ({32{alu_op_p0[8]}}  & sltu_res)
                  | ({32{alu_op_p0[7]}}  & (src1 & src2))
                  | ({32{alu_op_p0[6]}}  & ~(src1 | src2))
                  | ({32{alu_op_p0[5]}}  & (src1 | src2))
                  | ({32{alu_op_p0[4]}}  & (src1 ^ src2))
                  | ({32{alu_op_p0[3]}}  & sll_res)
                  | ({32{alu_op_p0[2]}}  & srl_res)
                  | ({32{alu_op_p0[1]}}  & sra_res)
                  | ({32{alu_op_p0[0]}}  & lui_res);

    // ---------------- stage boundary: execute -> memory / decode ----------------
    logic waddr_nz;
    assign waddr_nz = |rf_waddr_p0;

    assign bus.ex_to_mem_bus = {pc_p0, ram_en_p0, ram_wen_p0, sel_rf_res_p0,
                                rf_we_p0, rf_waddr_p0, result};

    // $0 is never a real destination, so it must not win a forwarding compare.
    // For loads the result is the address; decode relies on stallreq_load.
    assign bus.ex_to_id_bus  = {rf_we_p0 & waddr_nz, rf_waddr_p0, result};

    assign bus.stallreq_load = ram_en_p0 & ~(|ram_wen_p0) & rf_we_p0 & waddr_nz;

    assign bus.data_sram_en    = ram_en_p0;
    assign bus.data_sram_wen   = ram_wen_p0;
    assign bus.data_sram_addr  = result;
    assign bus.data_sram_wdata = rdata2_p0;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
// Scoreboard bench for ex_stage: each driven instruction pushes its expected
// outputs; after the capturing edge the entry is popped and every output bus
// is compared.
// ----------------------------------------------------------------------------
module tb_ex_stage;

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_AND  = 12'h080;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_XOR  = 12'h010;
    localparam logic [11:0] OP_SLL  = 12'h008;
    localparam logic [11:0] OP_SRL  = 12'h004;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    localparam logic [5:0] ST_RUN    = 6'b000000;
    localparam logic [5:0] ST_BUBBLE = 6'b000110;
    localparam logic [5:0] ST_HOLD   = 6'b001110;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_stage_if u_if ();

    ex_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  wen;
        logic        sel;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic [31:0] wdata;
        logic        fwd_we;
        logic        stallreq;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [158:0] mk_bus(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
        input logic [2:0] s1, input logic [3:0] s2, input logic re, input logic [3:0] rw,
        input logic we, input logic [4:0] wa, input logic sel,
        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, re, rw, we, wa, sel, r1, r2};
    endfunction

    function automatic exp_t mk_exp(
        input string tag, input logic [31:0] pc, input logic re, input logic [3:0] rw,
        input logic sel, input logic we, input logic [4:0] wa, input logic [31:0] res,
        input logic [31:0] wdata, input logic fwd, input logic stl);
        exp_t e;
        e.tag = tag; e.pc = pc; e.ram_en = re; e.wen = rw; e.sel = sel;
        e.rf_we = we; e.waddr = wa; e.result = res; e.wdata = wdata;
        e.fwd_we = fwd; e.stallreq = stl;
        return e;
    endfunction

    function automatic exp_t zero_exp(input string tag);
        return mk_exp(tag, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 128'(1), 128'(0));
            return;
        end
        e = sb_q.pop_front();
        check_val({e.tag, ".mem_bus"}, 128'(u_if.ex_to_mem_bus),
                  128'({e.pc, e.ram_en, e.wen, e.sel, e.rf_we, e.waddr, e.result}));
        check_val({e.tag, ".id_bus"}, 128'(u_if.ex_to_id_bus),
                  128'({e.fwd_we, e.waddr, e.result}));
        check_val({e.tag, ".stallreq"}, 128'(u_if.stallreq_load), 128'(e.stallreq));
        check_val({e.tag, ".sram_en"},  128'(u_if.data_sram_en),  128'(e.ram_en));
        check_val({e.tag, ".sram_wen"}, 128'(u_if.data_sram_wen), 128'(e.wen));
        check_val({e.tag, ".sram_addr"}, 128'(u_if.data_sram_addr), 128'(e.result));
        check_val({e.tag, ".sram_wdata"}, 128'(u_if.data_sram_wdata), 128'(e.wdata));
    endtask

    // Drive one cycle of input, queue what must appear after the edge, check it.
    task automatic step(input logic [158:0] b, input logic [5:0] st, input exp_t e);
        @(negedge clk);
        u_if.id_to_ex_bus = b;
        u_if.stall        = st;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    // Register-writing ALU instruction with no memory access.
    task automatic alu_step(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                            input logic [4:0] wa, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] res, input logic fwd);
        step(mk_bus(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, wa, 1'b0, r1, r2), ST_RUN,
             mk_exp(tag, pc, 1'b0, 4'h0, 1'b0, 1'b1, wa, res, r2, fwd, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [158:0] b_a;
        logic [158:0] b_h;
        logic [158:0] b_d;

        rst              = 1'b0;
        u_if.stall       = ST_RUN;
        u_if.id_to_ex_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(zero_exp("reset"));
        compare_out();
        @(negedge clk);
        rst = 1'b1;

        // Arithmetic / logic
        alu_step("addiu", 32'hBFC0_0000, 32'h2509_FFFF, OP_ADD, 3'b001, 4'b0010, 5'd9,
                 32'h0000_0005, 32'h1111_1111, 32'h0000_0004, 1'b1);
        alu_step("ori", 32'hBFC0_0004, 32'h34A5_8000, OP_OR, 3'b001, 4'b1000, 5'd5,
                 32'h0001_0000, 32'h2222_2222, 32'h0001_8000, 1'b1);
        alu_step("lui", 32'hBFC0_0008, 32'h3C06_1234, OP_LUI, 3'b000, 4'b1000, 5'd6,
                 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_0000, 1'b1);
        alu_step("sll", 32'hBFC0_000C, 32'h0007_3900, OP_SLL, 3'b100, 4'b0001, 5'd7,
                 32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_00F0, 1'b1);
        alu_step("jal", 32'hBFC0_0010, 32'h0FF0_0100, OP_ADD, 3'b010, 4'b0100, 5'd31,
                 32'hAAAA_AAAA, 32'h5555_5555, 32'hBFC0_0018, 1'b1);

        // Memory requests
        step(mk_bus(32'hBFC0_0014, 32'hAD09_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                    1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF), ST_RUN,
             mk_exp("sw", 32'hBFC0_0014, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0FFC,
                    32'hDEAD_BEEF, 1'b0, 1'b0));
        step(mk_bus(32'hBFC0_0018, 32'h8D28_0004, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                    1'b1, 5'd8, 1'b1, 32'h0000_2000, 32'h0000_0000), ST_RUN,
             mk_exp("lw8", 32'hBFC0_0018, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h0000_2004,
                    32'h0000_0000, 1'b1, 1'b1));
        step(mk_bus(32'hBFC0_001C, 32'h8D20_0010, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                    1'b1, 5'd0, 1'b1, 32'h0000_3000, 32'h0000_0000), ST_RUN,
             mk_exp("lw0", 32'hBFC0_001C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd0, 32'h0000_3010,
                    32'h0000_0000, 1'b0, 1'b0));

        // Destination $0, remaining ALU ops, boundary encodings
        alu_step("wr_r0", 32'hBFC0_0020, 32'h0, OP_ADD, 3'b001, 4'b0001, 5'd0,
                 32'h0000_0007, 32'h0000_0009, 32'h0000_0010, 1'b0);
        alu_step("sub", 32'hBFC0_0024, 32'h0, OP_SUB, 3'b001, 4'b0001, 5'd10,
                 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1);
        alu_step("slt", 32'hBFC0_0028, 32'h0, OP_SLT, 3'b001, 4'b0001, 5'd11,
                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1);
        alu_step("sltu_a", 32'hBFC0_002C, 32'h0, OP_SLTU, 3'b001, 4'b0001, 5'd11,
                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
        alu_step("sltu_b", 32'hBFC0_0030, 32'h0, OP_SLTU, 3'b001, 4'b0001, 5'd11,
                 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        alu_step("and", 32'hBFC0_0034, 32'h0, OP_AND, 3'b001, 4'b0001, 5'd12,
                 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1);
        alu_step("nor", 32'hBFC0_0038, 32'h0, OP_NOR, 3'b001, 4'b0001, 5'd12,
                 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b1);
        alu_step("xor", 32'hBFC0_003C, 32'h0, OP_XOR, 3'b001, 4'b0001, 5'd12,
                 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
        alu_step("srl", 32'hBFC0_0040, 32'h0000_0100, OP_SRL, 3'b100, 4'b0001, 5'd13,
                 32'hFFFF_FFFF, 32'h8000_0000, 32'h0800_0000, 1'b1);
        alu_step("sra", 32'hBFC0_0044, 32'h0000_0100, OP_SRA, 3'b100, 4'b0001, 5'd13,
                 32'hFFFF_FFFF, 32'h8000_0000, 32'hF800_0000, 1'b1);
        alu_step("multi_op", 32'hBFC0_0048, 32'h0, OP_ADD | OP_OR, 3'b001, 4'b0001, 5'd14,
                 32'h0000_0005, 32'h0000_0003, 32'h0000_000F, 1'b1);
        alu_step("no_op", 32'hBFC0_004C, 32'h0, 12'h000, 3'b001, 4'b0001, 5'd14,
                 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1);
        alu_step("no_src1", 32'hBFC0_0050, 32'h0, OP_ADD, 3'b000, 4'b0001, 5'd15,
                 32'h0000_0007, 32'h0000_0009, 32'h0000_0009, 1'b1);

        // Bubble: stall[2] alone flushes, the offered instruction is not taken
        b_a = mk_bus(32'hBFC0_0060, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3,
                     1'b0, 32'h0000_0001, 32'h0000_0002);
        step(b_a, ST_RUN, mk_exp("pre_bub", 32'hBFC0_0060, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3,
                                 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0));
        step(b_a, ST_BUBBLE, zero_exp("bubble"));
        step(b_a, ST_RUN, mk_exp("post_bub", 32'hBFC0_0060, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3,
                                 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0));

        // Hold: stall[2] and stall[3] freeze EX while a new instruction waits
        b_h = mk_bus(32'hBFC0_0070, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4,
                     1'b0, 32'h0000_0010, 32'h0000_0020);
        step(b_h, ST_RUN, mk_exp("pre_hold", 32'hBFC0_0070, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4,
                                 32'h0000_0030, 32'h0000_0020, 1'b1, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step(b_a, ST_HOLD, mk_exp($sformatf("hold%0d", i), 32'hBFC0_0070, 1'b0, 4'h0,
                                      1'b0, 1'b1, 5'd4, 32'h0000_0030, 32'h0000_0020,
                                      1'b1, 1'b0));
        end
        step(b_a, ST_RUN, mk_exp("post_hold", 32'hBFC0_0060, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3,
                                 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0));

        // Asynchronous reset mid-cycle, with a hold request pending
        b_d = mk_bus(32'hBFC0_0080, 32'h0, OP_ADD, 3'b001, 4'b0001, 1'b1, 4'h0, 1'b1, 5'd2,
                     1'b1, 32'h0000_4000, 32'h0000_0004);
        step(b_d, ST_RUN, mk_exp("pre_rst", 32'hBFC0_0080, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2,
                                 32'h0000_4004, 32'h0000_0004, 1'b1, 1'b1));
        #2;
        u_if.stall = ST_HOLD;
        rst = 1'b0;
        #1;
        sb_q.push_back(zero_exp("async_rst"));
        compare_out();
        @(negedge clk);
        rst = 1'b1;
        step(b_d, ST_HOLD, zero_exp("rst_discard"));
        step(b_d, ST_RUN, mk_exp("post_rst", 32'hBFC0_0080, 1'b1, 4'h0, 1'b1, 1'b1, 5'd2,
                                 32'h0000_4004, 32'h0000_0004, 1'b1, 1'b1));

        check_val("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
